// File: rtl/jstk_frame_rx.sv
// ----------------------------------------------------------------------------
// jstk_frame_rx
// Receive side of the joystick Bluetooth link, mounted on the car.
// Deserialises the 8N1 UART stream (idle high, LSB first) from the Bluetooth
// module and reassembles 3-byte frames {4'h0, Y[9:0], X[9:0]}, which are sent
// most-significant byte first. The latest good Y/X positions are presented to
// the steering logic together with a one-cycle frame_vld strobe.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active low
//   rx         in   UART serial input, asynchronous to CLK
//   y_pos      out  Y position of the last good frame
//   x_pos      out  X position of the last good frame
//   frame_vld  out  one-cycle pulse when y_pos/x_pos update
//   frame_err  out  one-cycle pulse when a frame is discarded
//   busy       out  byte in flight or frame partially assembled
//
// Bit FSM
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on the synchronised rx
//   START  | waiting half a bit to confirm the start bit
//   DATA   | sampling 8 data bits at mid-bit, LSB first
//   STOP   | sampling the stop bit
//   BREAK  | framing error seen, waiting for the line to return high
// ----------------------------------------------------------------------------
module jstk_frame_rx #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx,
   output logic [9:0] y_pos,
   output logic [9:0] x_pos,
   output logic       frame_vld,
   output logic       frame_err,
   output logic       busy
);

   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;
   localparam int TMO_CLKS = TIMEOUT_BITS * CPB;
   localparam int TW       = $clog2(CPB + 1);
   localparam int TOW      = $clog2(TMO_CLKS + 1);

   localparam logic [TW-1:0]  BIT_LOAD   = TW'(CPB - 1);
   // The edge-detect cycle already consumed one clock of the half bit.
   localparam logic [TW-1:0]  START_LOAD = TW'(HALF - 2);
   localparam logic [TOW-1:0] TMO_LOAD   = TOW'(TMO_CLKS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic           rx_meta_q, rx_s_q, rx_s_dly_q;
   logic [2:0]     state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [15:0]    frame_q, frame_d;
   logic [TOW-1:0] tmo_q, tmo_d;
   logic [9:0]     y_q, y_d, x_q, x_d;
   logic           vld_q, vld_d, err_q, err_d;
   logic           byte_ok, stop_err;
   logic [23:0]    word;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_s_dly_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         rx_s_dly_q <= rx_s_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_ok   = 1'b0;
      stop_err  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_s_dly_q && !rx_s_q) begin
               state_d = S_START;
               timer_d = START_LOAD;
            end
         end
         S_START: begin
            if (timer_q == '0) begin
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  timer_d   = BIT_LOAD;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_DATA: begin
            if (timer_q == '0) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               timer_d = BIT_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_STOP: begin
            if (timer_q == '0) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
                  byte_ok = 1'b1;
               end else begin
                  state_d  = S_BREAK;
                  stop_err = 1'b1;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_BREAK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign word = {frame_q, shift_q};

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      frame_d    = frame_q;
      tmo_d      = tmo_q;
      y_d        = y_q;
      x_d        = x_q;
      vld_d      = 1'b0;
      err_d      = 1'b0;

      if (stop_err) begin
         byte_cnt_d = 2'd0;
         err_d      = 1'b1;
      end else if (byte_ok) begin
         if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            if (word[23:20] == 4'h0) begin
               y_d   = word[19:10];
               x_d   = word[9:0];
               vld_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            frame_d    = {frame_q[7:0], shift_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
      end

      // Inter-byte gap timer; reloaded whenever a byte is in flight, so
      // every start bit restarts the gap measurement.
      if (state_q == S_IDLE && byte_cnt_q != 2'd0) begin
         if (tmo_q == '0) begin
            byte_cnt_d = 2'd0;
            err_d      = 1'b1;
            tmo_d      = TMO_LOAD;
         end else begin
            tmo_d = tmo_q - TOW'(1);
         end
      end else begin
         tmo_d = TMO_LOAD;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         byte_cnt_q <= 2'd0;
         frame_q    <= 16'h0000;
         tmo_q      <= '0;
         y_q        <= 10'h000;
         x_q        <= 10'h000;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         frame_q    <= frame_d;
         tmo_q      <= tmo_d;
         y_q        <= y_d;
         x_q        <= x_d;
         vld_q      <= vld_d;
         err_q      <= err_d;
      end
   end

   assign y_pos     = y_q;
   assign x_pos     = x_q;
   assign frame_vld = vld_q;
   assign frame_err = err_q;
   assign busy      = (state_q != S_IDLE) | (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_jstk_frame_rx.sv
module tb_jstk_frame_rx;

   localparam int CPB = 10;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       rx  = 1'b1;
   logic [9:0] y_pos, x_pos;
   logic       frame_vld, frame_err, busy;

   always #5 CLK = ~CLK;

   jstk_frame_rx #(
      .CLK_FREQ    (1_000_000),
      .BAUD        (100_000),
      .TIMEOUT_BITS(20)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .rx       (rx),
      .y_pos    (y_pos),
      .x_pos    (x_pos),
      .frame_vld(frame_vld),
      .frame_err(frame_err),
      .busy     (busy)
   );

   typedef struct {
      bit         is_err;
      logic [9:0] y;
      logic [9:0] x;
   } ev_t;

   ev_t        exp_q[$];
   int         n_cmp   = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         err_cyc = 0;
   logic [9:0] exp_y   = 10'h000;
   logic [9:0] exp_x   = 10'h000;

   function automatic void chk(input bit ok, input string name, input int act, input int req);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   // Reference decode of three received bytes into the expected event.
   function automatic void push_frame(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2);
      int  w;
      ev_t ev;
      w         = (int'(b0) << 16) + (int'(b1) << 8) + int'(b2);
      ev.is_err = ((w >> 20) != 0);
      ev.y      = 10'((w >> 10) % 1024);
      ev.x      = 10'(w % 1024);
      exp_q.push_back(ev);
   endfunction

   function automatic void push_err();
      ev_t ev;
      ev.is_err = 1'b1;
      ev.y      = 10'h000;
      ev.x      = 10'h000;
      exp_q.push_back(ev);
   endfunction

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_v);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      ev_t ev;
      cyc++;
      if (!RST) begin
         chk(y_pos == 0 && x_pos == 0 && !frame_vld && !frame_err && !busy,
             "reset_outputs", {y_pos, x_pos, frame_vld, frame_err, busy}, 0);
         exp_y = 10'h000;
         exp_x = 10'h000;
      end else begin
         chk(!(frame_vld && frame_err), "strobe_exclusive", {frame_vld, frame_err}, 0);
         if (frame_vld) begin
            chk(exp_q.size() != 0, "unexpected_frame_vld", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
               ev = exp_q.pop_front();
               chk(!ev.is_err, "vld_where_err_expected", 1, 0);
               if (!ev.is_err) begin
                  exp_y = ev.y;
                  exp_x = ev.x;
               end
            end
         end
         if (frame_err) begin
            err_cyc = cyc;
            chk(exp_q.size() != 0, "unexpected_frame_err", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
               ev = exp_q.pop_front();
               chk(ev.is_err, "err_where_vld_expected", 1, 0);
            end
         end
         chk(y_pos == exp_y, "y_pos_model", y_pos, exp_y);
         chk(x_pos == exp_x, "x_pos_model", x_pos, exp_x);
      end
   end

   initial begin
      int gap, start_cyc, n;

      RST = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge CLK);
      chk(y_pos == 10'h000 && x_pos == 10'h000, "reset_pos", {y_pos, x_pos}, 0);
      chk(busy == 1'b0, "reset_busy", busy, 0);
      RST = 1'b1;
      idle(5);

      // 1: good frame
      push_frame(8'h02, 8'h01, 8'hFF);
      send_byte(8'h02, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(20);
      chk(y_pos == 10'h080, "t1_y", y_pos, 10'h080);
      chk(x_pos == 10'h1FF, "t1_x", x_pos, 10'h1FF);
      chk(busy == 1'b0, "t1_busy_low", busy, 0);
      chk(exp_q.size() == 0, "t1_pending", exp_q.size(), 0);

      // 2: bad header
      push_frame(8'hF2, 8'h01, 8'hFF);
      send_byte(8'hF2, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(20);
      chk(y_pos == 10'h080 && x_pos == 10'h1FF, "t2_hold", {y_pos, x_pos}, {10'h080, 10'h1FF});
      chk(exp_q.size() == 0, "t2_pending", exp_q.size(), 0);

      // 3: stop-bit error on byte 2, then a valid frame
      push_err();
      send_byte(8'h00, 1'b1);
      send_byte(8'h55, 1'b0);
      idle(20);
      push_frame(8'h03, 8'hFF, 8'h00);
      send_byte(8'h03, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(20);
      chk(y_pos == 10'h0FF, "t3_y", y_pos, 10'h0FF);
      chk(x_pos == 10'h300, "t3_x", x_pos, 10'h300);
      chk(exp_q.size() == 0, "t3_pending", exp_q.size(), 0);

      // 4: inter-byte timeout, then a valid frame
      push_err();
      send_byte(8'h00, 1'b1);
      send_byte(8'h05, 1'b1);
      start_cyc = cyc;
      idle(250);
      gap = err_cyc - start_cyc;
      chk(gap >= 192 && gap <= 203, "t4_timeout_gap_clks", gap, 200);
      push_frame(8'h01, 8'h00, 8'h02);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      idle(20);
      chk(y_pos == 10'h040, "t4_y", y_pos, 10'h040);
      chk(x_pos == 10'h002, "t4_x", x_pos, 10'h002);
      chk(exp_q.size() == 0, "t4_pending", exp_q.size(), 0);

      // 5: short glitch, then a long low pulse
      rx = 1'b0;
      repeat (3) @(negedge CLK);
      rx = 1'b1;
      n = 0;
      while (busy && n < 10) begin
         @(negedge CLK);
         n++;
      end
      chk(n <= 5 && !busy, "t5_glitch_busy_release", n, 5);
      idle(20);
      chk(exp_q.size() == 0, "t5_glitch_no_event", exp_q.size(), 0);
      push_err();
      rx = 1'b0;
      repeat (40) @(negedge CLK);
      idle(350);
      chk(exp_q.size() == 0, "t5_low_hold_one_err", exp_q.size(), 0);
      chk(busy == 1'b0, "t5_busy_low", busy, 0);

      // 6: reset in the middle of byte 2
      send_byte(8'h12, 1'b1);
      drive_bit(1'b0);
      rx = 1'b1;
      repeat (5) @(negedge CLK);
      chk(busy == 1'b1, "t6_busy_mid_frame", busy, 1);
      #2 RST = 1'b0;
      #1;
      chk(y_pos == 10'h000 && x_pos == 10'h000, "t6_reset_pos", {y_pos, x_pos}, 0);
      chk(!busy && !frame_vld && !frame_err, "t6_reset_flags", {busy, frame_vld, frame_err}, 0);
      rx = 1'b1;
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      idle(5);
      push_frame(8'h00, 8'h00, 8'h01);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(20);
      chk(y_pos == 10'h000, "t6_y", y_pos, 0);
      chk(x_pos == 10'h001, "t6_x", x_pos, 1);
      chk(exp_q.size() == 0, "t6_pending", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
